// File: rtl/hour_counter_bcd12.sv
// 12-hour BCD hour counter: advances on minute carry in RUN mode and supports
// inc/dec stepping with hold-to-repeat plus a checked BCD load in SET mode.
//   state  | meaning
//   ST_RUN | counting minute carries, adjust/load inputs ignored
//   ST_SET | minute carries dropped, adjust/load inputs active
module hour_counter_bcd12 #(
  parameter int RESET_HOUR = 12,
  parameter int RPT_DELAY  = 500,
  parameter int RPT_PERIOD = 100,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       min_carry,
  input  logic       set_en,
  input  logic       adj_inc,
  input  logic       adj_dec,
  input  logic       set_valid,
  input  logic [3:0] set_tens,
  input  logic [3:0] set_units,
  output logic [3:0] hour_tens,
  output logic [3:0] hour_units,
  output logic       hour_carry,
  output logic       set_ack,
  output logic       set_err
);

  typedef enum logic {ST_RUN, ST_SET} state_t;

  localparam logic [7:0] RST_BCD = (RESET_HOUR >= 10) ?
                                   {4'd1, 4'(RESET_HOUR - 10)} : {4'd0, 4'(RESET_HOUR)};
  localparam logic [CNT_W-1:0] DELAY_LD  = CNT_W'(RPT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LD = CNT_W'(RPT_PERIOD - 1);

  state_t           state;
  logic [7:0]       hour_q;
  logic [CNT_W-1:0] rpt_cnt;
  logic             rpt_active;
  logic             inc_q;
  logic             dec_q;

  logic inc_only;
  logic dec_only;
  logic step_rise;
  logic step_held;

  function automatic logic [7:0] bcd_inc(input logic [7:0] h);
    if (h == 8'h12)      return 8'h01;
    else if (h == 8'h09) return 8'h10;
    else                 return h + 8'h01;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] h);
    if (h == 8'h01)      return 8'h12;
    else if (h == 8'h10) return 8'h09;
    else                 return h - 8'h01;
  endfunction

  function automatic logic bcd_legal(input logic [3:0] t, input logic [3:0] u);
    return ((t == 4'd0) && (u >= 4'd1) && (u <= 4'd9)) ||
           ((t == 4'd1) && (u <= 4'd2));
  endfunction

  assign inc_only  = adj_inc & ~adj_dec;
  assign dec_only  = adj_dec & ~adj_inc;
  assign step_rise = (inc_only & ~inc_q) | (dec_only & ~dec_q);
  assign step_held = ((inc_only & inc_q) | (dec_only & dec_q)) & rpt_active;

  assign hour_tens  = hour_q[7:4];
  assign hour_units = hour_q[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      hour_q     <= RST_BCD;
      hour_carry <= 1'b0;
      set_ack    <= 1'b0;
      set_err    <= 1'b0;
      rpt_cnt    <= '0;
      rpt_active <= 1'b0;
      inc_q      <= 1'b0;
      dec_q      <= 1'b0;
    end else begin
      hour_carry <= 1'b0;
      set_ack    <= 1'b0;
      set_err    <= 1'b0;
      inc_q      <= adj_inc;
      dec_q      <= adj_dec;
      state      <= set_en ? ST_SET : ST_RUN;

      case (state)
        ST_RUN: begin
          rpt_cnt    <= '0;
          rpt_active <= 1'b0;
          if (min_carry) begin
            hour_q     <= bcd_inc(hour_q);
            hour_carry <= (hour_q == 8'h11);
          end
        end

        ST_SET: begin
          if (set_valid) begin
            if (bcd_legal(set_tens, set_units)) begin
              hour_q  <= {set_tens, set_units};
              set_ack <= 1'b1;
            end else begin
              set_err <= 1'b1;
            end
          end else if (step_rise) begin
            hour_q     <= inc_only ? bcd_inc(hour_q) : bcd_dec(hour_q);
            rpt_cnt    <= DELAY_LD;
            rpt_active <= 1'b1;
          end else if (step_held) begin
            // Terminal count fires a repeat step and reloads the shorter period.
            if (rpt_cnt == '0) begin
              hour_q  <= inc_only ? bcd_inc(hour_q) : bcd_dec(hour_q);
              rpt_cnt <= PERIOD_LD;
            end else begin
              rpt_cnt <= rpt_cnt - CNT_W'(1);
            end
          end else begin
            rpt_cnt    <= '0;
            rpt_active <= 1'b0;
          end

          if (!set_en) begin
            rpt_cnt    <= '0;
            rpt_active <= 1'b0;
          end
        end

        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hour_counter_bcd12.sv
// Randomised bench for hour_counter_bcd12; a cycle-level reference model tracks
// the hour as a plain integer 1..12 and repeat timing as cycles-since-press.
`timescale 1ns/1ps
module tb_hour_counter_bcd12;

  localparam int DLY = 4;
  localparam int PER = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       min_carry, set_en, adj_inc, adj_dec, set_valid;
  logic [3:0] set_tens, set_units;
  logic [3:0] hour_tens, hour_units;
  logic       hour_carry, set_ack, set_err;

  int n_checks = 0;
  int n_errors = 0;

  int m_hour;
  bit m_set, m_prev_inc, m_prev_dec, m_active;
  int m_k;
  bit e_carry, e_ack, e_err;

  hour_counter_bcd12 #(
    .RESET_HOUR(12), .RPT_DELAY(DLY), .RPT_PERIOD(PER), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .min_carry(min_carry), .set_en(set_en),
    .adj_inc(adj_inc), .adj_dec(adj_dec), .set_valid(set_valid),
    .set_tens(set_tens), .set_units(set_units), .hour_tens(hour_tens),
    .hour_units(hour_units), .hour_carry(hour_carry), .set_ack(set_ack),
    .set_err(set_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_val(input string tag, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, req, $time);
    end
  endtask

  function automatic int to_bcd(input int h);
    return ((h / 10) << 4) | (h % 10);
  endfunction

  task automatic model_reset();
    m_hour = 12; m_set = 0; m_prev_inc = 0; m_prev_dec = 0;
    m_active = 0; m_k = 0; e_carry = 0; e_ack = 0; e_err = 0;
  endtask

  // Advance the model by one clock using the inputs the DUT is about to sample.
  task automatic model_step();
    bit up;
    bit prev;
    bit do_step;
    int val;
    e_carry = 0; e_ack = 0; e_err = 0;
    do_step = 0;
    up = adj_inc;
    if (!m_set) begin
      m_active = 0;
      if (min_carry) begin
        m_hour  = m_hour % 12 + 1;
        e_carry = (m_hour == 12);
      end
    end else begin
      if (set_valid) begin
        val = int'(set_tens) * 10 + int'(set_units);
        if (set_tens <= 1 && set_units <= 9 && val >= 1 && val <= 12) begin
          m_hour = val; e_ack = 1;
        end else begin
          e_err = 1;
        end
      end else if (adj_inc && adj_dec) begin
        m_active = 0;
      end else if (adj_inc || adj_dec) begin
        prev = up ? m_prev_inc : m_prev_dec;
        if (!prev) begin
          do_step = 1; m_active = 1; m_k = 0;
        end else if (m_active) begin
          m_k++;
          if (m_k >= DLY && (m_k - DLY) % PER == 0) do_step = 1;
        end
      end else begin
        m_active = 0;
      end
      if (do_step) m_hour = up ? (m_hour % 12 + 1) : (m_hour == 1 ? 12 : m_hour - 1);
      if (!set_en) m_active = 0;
    end
    m_prev_inc = adj_inc;
    m_prev_dec = adj_dec;
    m_set      = set_en;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_val("hour",  int'({hour_tens, hour_units}), to_bcd(m_hour));
    check_val("carry", int'(hour_carry), int'(e_carry));
    check_val("ack",   int'(set_ack), int'(e_ack));
    check_val("err",   int'(set_err), int'(e_err));
  endtask

  task automatic load(input int t, input int u);
    set_tens = 4'(t); set_units = 4'(u); set_valid = 1;
    tick();
    set_valid = 0;
  endtask

  initial begin
    int op, len;
    rst_n = 0; min_carry = 0; set_en = 0; adj_inc = 0; adj_dec = 0;
    set_valid = 0; set_tens = 0; set_units = 0;
    model_reset();
    #12;
    check_val("rst_hour",  int'({hour_tens, hour_units}), 'h12);
    check_val("rst_carry", int'(hour_carry), 0);
    check_val("rst_ack",   int'(set_ack), 0);
    check_val("rst_err",   int'(set_err), 0);
    @(posedge clk); #1; rst_n = 1;

    // Full RUN cycle through all twelve hours, carry only into 12.
    for (int i = 0; i < 12; i++) begin
      min_carry = 1; tick(); min_carry = 0; tick();
    end
    check_val("run_wrap", int'({hour_tens, hour_units}), 'h12);

    // SET loads: legal and illegal.
    set_en = 1; tick(); tick();
    load(0, 7);
    check_val("load07", int'({hour_tens, hour_units}), 'h07);
    check_val("ack07",  int'(set_ack), 1);
    tick();
    check_val("ack_pulse", int'(set_ack), 0);
    load(1, 3);
    check_val("load13", int'({hour_tens, hour_units}), 'h07);
    check_val("err13",  int'(set_err), 1);

    // Hold-to-repeat from 12: press step plus two repeat steps.
    load(1, 2);
    adj_inc = 1;
    repeat (DLY + 2 * PER) tick();
    adj_inc = 0; tick();
    check_val("repeat", int'({hour_tens, hour_units}), 'h03);

    // Decrement wrap and both-pressed no-op.
    load(0, 1);
    adj_dec = 1; tick(); adj_dec = 0; tick();
    check_val("dec_wrap", int'({hour_tens, hour_units}), 'h12);
    adj_inc = 1; adj_dec = 1; repeat (3) tick();
    adj_inc = 0; adj_dec = 0; tick();
    check_val("both", int'({hour_tens, hour_units}), 'h12);

    // Minute carries dropped in SET, then reset in the middle of a repeat.
    repeat (3) begin min_carry = 1; tick(); min_carry = 0; tick(); end
    check_val("set_drop", int'({hour_tens, hour_units}), 'h12);
    adj_inc = 1; repeat (5) tick();
    #2; rst_n = 0; adj_inc = 0; set_en = 0;
    #1;
    model_reset();
    check_val("mid_rst_hour",  int'({hour_tens, hour_units}), 'h12);
    check_val("mid_rst_carry", int'(hour_carry), 0);
    check_val("mid_rst_ack",   int'(set_ack), 0);
    @(posedge clk); #1; rst_n = 1;
    min_carry = 1; tick(); min_carry = 0;
    check_val("post_rst_run", int'({hour_tens, hour_units}), 'h01);

    // Randomised mix of operations against the model.
    for (int n = 0; n < 500; n++) begin
      op = $urandom_range(0, 6);
      case (op)
        0: begin min_carry = 1; tick(); min_carry = 0; end
        1: begin set_en = ~set_en; tick(); end
        2: load($urandom_range(0, 2), $urandom_range(0, 11));
        3, 4: begin
          len = $urandom_range(1, 12);
          if (op == 3) adj_inc = 1; else adj_dec = 1;
          for (int j = 0; j < len; j++) begin
            min_carry = 1'($urandom_range(0, 1));
            tick();
          end
          min_carry = 0; adj_inc = 0; adj_dec = 0; tick();
        end
        5: begin
          adj_inc = 1; tick();
          adj_dec = 1; repeat ($urandom_range(1, 3)) tick();
          adj_inc = 0; repeat ($urandom_range(1, 3)) tick();
          adj_dec = 0; tick();
        end
        default: begin
          len = $urandom_range(1, 3);
          for (int j = 0; j < len; j++) begin
            min_carry = 1'($urandom_range(0, 1));
            tick();
          end
          min_carry = 0;
        end
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
